// File: rtl/audio_mixer_seq.sv
// Sequential audio mixer: scales, routes and sums NCH unsigned channels, one
// channel per cycle, into saturated left/right outputs with an optional mono downmix.
module audio_mixer_seq #(
    parameter int NCH = 4,
    parameter int IW  = 8,
    parameter int OW  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_stb,
    input  logic [NCH*IW-1:0] ch_data,
    input  logic [NCH*4-1:0]  ch_vol,
    input  logic [NCH*2-1:0]  ch_pan,
    input  logic              mono,
    input  logic              ovr_clr,
    output logic [OW-1:0]     audio_l,
    output logic [OW-1:0]     audio_r,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int TW    = OW - 1;
    localparam int SHIFT = OW - 1 - IW - 4;
    localparam int AW    = OW - 1 + $clog2(NCH) + 1;
    localparam int IDXW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);
    localparam logic [AW-1:0]   MAX_POS  = {{(AW - TW){1'b0}}, {TW{1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUTPUT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              latch_en;
    logic              accum_en;
    logic              output_en;

    logic [NCH*IW-1:0] sh_data;
    logic [NCH*4-1:0]  sh_vol;
    logic [NCH*2-1:0]  sh_pan;
    logic              sh_mono;
    logic [IDXW-1:0]   idx_q;
    logic [AW-1:0]     acc_l;
    logic [AW-1:0]     acc_r;

    logic [IW-1:0]     cur_sample;
    logic [3:0]        cur_vol;
    logic [1:0]        cur_pan;
    logic [IW+3:0]     product;
    logic [TW-1:0]     term;
    logic [AW-1:0]     term_ext;
    logic [AW-1:0]     mix_sum;
    logic [AW-1:0]     mix_half;

    // Clamp an accumulator to the positive half of the signed output range.
    function automatic logic [OW-1:0] saturate(input logic [AW-1:0] value);
        if (value > MAX_POS) begin
            return {1'b0, {TW{1'b1}}};
        end
        return {1'b0, value[TW-1:0]};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        latch_en  = 1'b0;
        accum_en  = 1'b0;
        output_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_stb) begin
                    latch_en = 1'b1;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                accum_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                output_en = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

    // The product is at most IW+4 bits; shifting it left aligns full scale with the output MSB.
    assign cur_sample = sh_data[idx_q*IW +: IW];
    assign cur_vol    = sh_vol[idx_q*4 +: 4];
    assign cur_pan    = sh_pan[idx_q*2 +: 2];
    assign product    = {4'b0000, cur_sample} * {{IW{1'b0}}, cur_vol};
    assign term       = TW'(product) << SHIFT;
    assign term_ext   = {{(AW - TW){1'b0}}, term};
    assign mix_sum    = acc_l + acc_r;
    assign mix_half   = mix_sum >> 1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_data   <= '0;
            sh_vol    <= '0;
            sh_pan    <= '0;
            sh_mono   <= 1'b0;
            idx_q     <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            audio_l   <= '0;
            audio_r   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= output_en;
            if (latch_en) begin
                sh_data <= ch_data;
                sh_vol  <= ch_vol;
                sh_pan  <= ch_pan;
                sh_mono <= mono;
                idx_q   <= '0;
                acc_l   <= '0;
                acc_r   <= '0;
            end else if (accum_en) begin
                idx_q <= idx_q + 1'b1;
                if (cur_pan[0]) begin
                    acc_l <= acc_l + term_ext;
                end
                if (cur_pan[1]) begin
                    acc_r <= acc_r + term_ext;
                end
            end
            if (output_en) begin
                if (sh_mono) begin
                    audio_l <= saturate(mix_half);
                    audio_r <= saturate(mix_half);
                end else begin
                    audio_l <= saturate(acc_l);
                    audio_r <= saturate(acc_r);
                end
            end
        end
    end

    // A strobe that cannot be accepted wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (sample_stb && busy) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: doc/audio_mixer_seq.md
AUDIO_MIXER_SEQ -- requirements
Module: audio_mixer_seq

Interface
REQ-001 Parameter NCH, default 4: number of input channels, legal range 1..8.
REQ-002 Parameter IW, default 8: unsigned sample width per channel; OW-1 >= IW+4 SHALL hold.
REQ-003 Parameter OW, default 16: output width, two's-complement, positive half used (0..2^(OW-1)-1).
REQ-004 clk  in  1  single mixer clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 sample_stb  in  1  one-cycle pulse requesting a new mixed sample.
REQ-007 ch_data  in  NCH*IW  packed unsigned channel samples; channel k at bits [k*IW +: IW].
REQ-008 ch_vol  in  NCH*4  per-channel volume 0..15; channel k at bits [k*4 +: 4].
REQ-009 ch_pan  in  NCH*2  per-channel routing: 00 mute, 01 left, 10 right, 11 both.
REQ-010 mono  in  1  1 = both outputs carry the mono downmix.
REQ-011 ovr_clr  in  1  clears the sticky overrun flag.
REQ-012 audio_l  out  OW  left mixed sample.
REQ-013 audio_r  out  OW  right mixed sample.
REQ-014 out_valid  out  1  one-cycle pulse when audio_l/audio_r update.
REQ-015 busy  out  1  high while a mix is in progress.
REQ-016 overrun  out  1  sticky; set when sample_stb arrives while busy.

Function
REQ-017 FSM states: IDLE, ACCUM, OUTPUT.
REQ-018 IDLE + sample_stb: latch ch_data, ch_vol, ch_pan and mono into shadow registers; clear acc_l and acc_r; channel index <= 0; go to ACCUM.
REQ-019 Inputs changing after the latch cycle SHALL NOT affect the sample in progress.
REQ-020 ACCUM handles one channel per cycle, index 0..NCH-1.
REQ-021 Channel term = (sample * vol) << (OW-1-IW-4); the term is unsigned.
REQ-022 The term is added to acc_l if pan[0] is set, and to acc_r if pan[1] is set.
REQ-023 After index NCH-1 the FSM goes to OUTPUT.
REQ-024 Accumulator width SHALL be OW-1+clog2(NCH)+1 bits, so no internal wrap is possible.
REQ-025 OUTPUT, mono=0: audio_l = min(acc_l, 2^(OW-1)-1); audio_r likewise from acc_r.
REQ-026 OUTPUT, mono=1: both outputs = min((acc_l+acc_r)>>1, 2^(OW-1)-1).
REQ-027 OUTPUT asserts out_valid for exactly one cycle, then returns to IDLE.
REQ-028 Outputs hold their value between out_valid pulses.
REQ-029 Latency: strobe at cycle T gives out_valid at cycle T+NCH+2; the registered outputs are valid in the same cycle.
REQ-030 busy = 1 in ACCUM and OUTPUT, 0 in IDLE.
REQ-031 A strobe in IDLE is accepted in the same cycle.
REQ-032 A strobe while busy is dropped, sets overrun, and does not disturb the mix in progress.
REQ-033 A strobe in the same cycle the FSM is in OUTPUT counts as busy: it is dropped and sets overrun.
REQ-034 ovr_clr clears overrun.
REQ-035 ovr_clr and a dropped strobe in the same cycle: set wins, overrun = 1.
REQ-036 vol=0 or pan=00 contributes exactly 0.

Reset
REQ-037 While reset_n = 0, and asynchronously on its assertion: FSM = IDLE; audio_l = audio_r = 0; out_valid = 0; busy = 0; overrun = 0; accumulators and shadow registers = 0.
REQ-038 Reset asserted mid-mix aborts the mix; no out_valid is produced for the aborted sample.
REQ-039 The first strobe accepted after reset_n rises is the first strobe seen in a cycle with reset_n = 1.

Verification
REQ-040 Defaults. ch0 = 0xFF, vol 15, pan 11; other channels muted; strobe at T -> out_valid at T+6; audio_l = audio_r = 0x7788.
REQ-041 Saturation. All 4 channels 0xFF, vol 15, pan 01 -> audio_l = 0x7FFF, audio_r = 0x0000.
REQ-042 Mono. ch0 = 0x80 vol 8 pan 01, ch1 = 0x40 vol 8 pan 10, mono=1 -> audio_l = audio_r = 0x1800.
REQ-043 Overrun. Second strobe at T+2 -> one out_valid only; overrun = 1 from T+3. ovr_clr pulse with no strobe -> overrun = 0 on the next cycle.
REQ-044 Input latch. Change ch_data at T+1 -> output reflects the values sampled at T.
REQ-045 Reset mid-mix. reset_n low at T+3 -> outputs 0 immediately, no out_valid. A new strobe after release -> normal result with latency NCH+2.
